// File: rtl/data_mem_pkg.sv
// Shared types, legality constants and helpers for the synchronous data memory.
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } mem_state_e;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 2;

    function automatic bit read_latency_ok(input int unsigned rl);
        return (rl >= READ_LATENCY_MIN) && (rl <= READ_LATENCY_MAX);
    endfunction

    function automatic int unsigned byte_lanes(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/data_mem_rsp_pipe.sv
// Fixed-latency response delay line carrying valid, error flag and read data.
module data_mem_rsp_pipe #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             err_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic             err_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q [LATENCY];
    logic             err_q   [LATENCY];
    logic [WIDTH-1:0] data_q  [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q[0] <= 1'b0;
        end else begin
            valid_q[0] <= valid_i;
        end
        err_q[0]  <= err_i;
        data_q[0] <= data_i;
    end

    for (genvar g = 1; g < LATENCY; g++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q[g] <= 1'b0;
            end else begin
                valid_q[g] <= valid_q[g-1];
            end
            err_q[g]  <= err_q[g-1];
            data_q[g] <= data_q[g-1];
        end
    end

    // Payload registers carry no reset; gating by valid keeps idle outputs at zero.
    assign valid_o = valid_q[LATENCY-1];
    assign err_o   = valid_q[LATENCY-1] & err_q[LATENCY-1];
    assign data_o  = valid_q[LATENCY-1] ? data_q[LATENCY-1] : '0;

endmodule

// File: rtl/sync_data_memory.sv
// Single-port byte-writable data memory with zero-fill sweep and fixed-latency responses.
module sync_data_memory
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic                    ReqWrite,
    input  logic [ADDR_WIDTH-1:0]   ReqAddr,
    input  logic [DATA_WIDTH-1:0]   ReqWData,
    input  logic [DATA_WIDTH/8-1:0] ReqByteEn,
    input  logic                    ClearReq,
    output logic                    RspValid,
    output logic [DATA_WIDTH-1:0]   RspRData,
    output logic                    RspErr,
    output logic                    Busy
);

    localparam int unsigned LANES = byte_lanes(DATA_WIDTH);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_dw
        $fatal(1, "sync_data_memory: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_WIDTH))) begin : g_bad_depth
        $fatal(1, "sync_data_memory: DEPTH must lie in 1..2**ADDR_WIDTH");
    end
    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_rl
        $fatal(1, "sync_data_memory: READ_LATENCY must be 1 or 2");
    end

    mem_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  accept;
    logic                  in_range;
    logic [IDX_W-1:0]      req_idx;
    logic [IDX_W-1:0]      clr_idx;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rsp_data;

    assign ReqReady = (state_q == IDLE);
    assign Busy     = (state_q == CLEAR);
    assign accept   = ReqValid & ReqReady;
    assign in_range = (32'(ReqAddr) < DEPTH);
    assign req_idx  = ReqAddr[IDX_W-1:0];
    assign clr_idx  = clr_ptr_q[IDX_W-1:0];
    assign wr_en    = accept & ReqWrite & in_range & ~rst;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            IDLE: begin
                if (ClearReq) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Sweep and request writes never coincide: requests are only accepted in IDLE.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_idx] <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (ReqByteEn[b]) begin
                    mem_q[req_idx][b*8 +: 8] <= ReqWData[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word  = '0;
        rsp_data = '0;
        if (in_range) begin
            rd_word = mem_q[req_idx];
        end
        if (!ReqWrite) begin
            rsp_data = rd_word;
        end
    end

    data_mem_rsp_pipe #(
        .WIDTH   (DATA_WIDTH),
        .LATENCY (READ_LATENCY)
    ) u_rsp_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (accept),
        .err_i   (~in_range),
        .data_i  (rsp_data),
        .valid_o (RspValid),
        .err_o   (RspErr),
        .data_o  (RspRData)
    );

endmodule

// File: doc/sync_data_memory.md
SYNC_DATA_MEMORY -- requirements
Module: sync_data_memory

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4: address bus width.
REQ-003 The block SHALL have parameter DEPTH, default 8: number of words, with 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter READ_LATENCY, default 1: response delay in cycles; legal values are 1 and 2.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have these ports:
  - clk  in  1  clock
  - rst  in  1  synchronous active-high reset
  - ReqValid  in  1  request present
  - ReqReady  out  1  block accepts a request this cycle
  - ReqWrite  in  1  1 = write, 0 = read
  - ReqAddr  in  ADDR_WIDTH  word address
  - ReqWData  in  DATA_WIDTH  write data
  - ReqByteEn  in  DATA_WIDTH/8  per-byte write enable
  - ClearReq  in  1  request a zero-fill of the whole array
  - RspValid  out  1  response present (single cycle)
  - RspRData  out  DATA_WIDTH  read data
  - RspErr  out  1  request address was out of range
  - Busy  out  1  clear sweep in progress

Function
REQ-010 A request SHALL be accepted on a rising clk edge where ReqValid and ReqReady are both 1.
REQ-011 ReqReady SHALL equal 1 exactly when the FSM is in IDLE.
REQ-012 A write SHALL update only the bytes whose ReqByteEn bit is 1, at the accept edge.
REQ-013 A read SHALL sample the array at the accept edge, so a read accepted the cycle after a write returns the written data.
REQ-014 Every accepted request, read or write, SHALL produce exactly one response with RspValid=1 for one cycle, READ_LATENCY cycles after the accept edge.
REQ-015 Responses SHALL be returned in order, with one request accepted per cycle at full throughput; there is no response backpressure.
REQ-016 For a write response, and whenever RspValid=0, RspRData SHALL be 0.
REQ-017 When ReqAddr >= DEPTH: no array update, RspErr=1 on that response, RspRData=0.
REQ-018 The FSM SHALL have two states, CLEAR and IDLE.
  - CLEAR: writes 0 to word ClrPtr each cycle, ClrPtr incrementing from 0; after the edge that writes word DEPTH-1, moves to IDLE.
  - IDLE: moves to CLEAR with ClrPtr=0 on the edge where ClearReq=1.
REQ-019 If ClearReq=1 and ReqValid=1 in the same IDLE cycle, the request SHALL still be accepted, and the clear SHALL start on the next cycle.
REQ-020 ClearReq SHALL be ignored while in CLEAR; Busy SHALL equal 1 exactly in CLEAR.
REQ-021 Responses already in flight when a clear starts SHALL still be delivered with their pre-clear read data.
REQ-022 ClrPtr SHALL be ADDR_WIDTH bits wide and SHALL NOT wrap, because the sweep terminates at DEPTH-1.

Reset
REQ-030 On a clk edge with rst=1, the FSM SHALL enter CLEAR with ClrPtr=0.
REQ-031 On a clk edge with rst=1, every response-pipeline valid bit SHALL be cleared; in-flight responses are dropped.
REQ-032 In the cycle after reset: RspValid=0, RspErr=0, RspRData=0, Busy=1, ReqReady=0.
REQ-033 After rst deasserts, the array SHALL read all-zero once Busy falls, which takes DEPTH cycles.
REQ-034 Reset asserted mid-sweep SHALL restart the sweep from word 0.

Structure
REQ-040 Package data_mem_pkg SHALL hold:
  - the state enum (CLEAR, IDLE);
  - the legal-READ_LATENCY check constant;
  - the byte-lane count function DATA_WIDTH/8.
REQ-041 The READ_LATENCY delay line (valid, err, data) SHALL be the sub-module data_mem_rsp_pipe, parameterised by width and latency.
REQ-042 An illegal DATA_WIDTH, DEPTH or READ_LATENCY SHALL fail elaboration.

Verification (DATA_WIDTH=16, ADDR_WIDTH=4, DEPTH=8, READ_LATENCY=1 unless stated)
REQ-050 Reset, then release:
  - ReqReady=0 and Busy=1 for 8 cycles, then ReqReady=1.
  - Then read addr 3 -> RspRData=0x0000, RspErr=0.
REQ-051 Write 0xABCD to addr 2 with BE=11, then write 0x1234 to addr 2 with BE=01, then read addr 2 -> 0xAB34.
REQ-052 Write 0x5555 to addr 5 accepted at cycle n, read addr 5 accepted at n+1:
  - write response at n+1 with RspRData=0;
  - read response at n+2 with 0x5555.
REQ-053 Write 0xFFFF to addr 9 -> RspErr=1 and RspRData=0.
  - Then read addr 1 -> previous contents unchanged.
  - No array word was modified.
REQ-054 Fill addrs 0-7 with 0x00A0+addr; pulse ClearReq; assert rst at sweep cycle 4; release.
  - Busy stays 1 for 8 further cycles.
  - All 8 words then read 0x0000.
REQ-055 With READ_LATENCY=2, reads to addrs 0-7 issued back-to-back:
  - responses appear in order, each exactly 2 cycles after its accept;
  - no bubbles between responses.
